// File: rtl/ex_div.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit for the EX stage.
// Restoring shift-subtract, one quotient bit per cycle, stalls the pipe via hold_req_o.
module ex_div #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic [4:0]      rd_addr_i,
  output logic [XLEN-1:0] result_o,
  output logic            ready_o,
  output logic [4:0]      rd_addr_o,
  output logic            busy_o,
  output logic            hold_req_o
);

  localparam int unsigned CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_CALC  = 2'd2,
    S_END   = 2'd3
  } state_t;

  state_t state_q, state_d;

  // op_q[0] = unsigned, op_q[1] = remainder; funct3[2] is always set for this unit
  logic [1:0]      op_q;
  logic [XLEN-1:0] dvnd_q;
  logic [XLEN-1:0] dvsr_q;
  logic [XLEN-1:0] quot_q;
  logic [XLEN-1:0] rem_q;
  logic [4:0]      rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic            neg_q_q;
  logic            neg_r_q;

  logic            unused_op;
  logic            is_signed;
  logic            dvnd_neg;
  logic            dvsr_neg;
  logic [XLEN-1:0] dvnd_abs;
  logic [XLEN-1:0] dvsr_abs;
  logic            div_zero;
  logic            overflow;
  logic            special;
  logic [XLEN-1:0] sp_quot;
  logic [XLEN-1:0] sp_rem;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] rem_nxt;
  logic [XLEN-1:0] quot_nxt;
  logic [XLEN-1:0] quot_fix;
  logic [XLEN-1:0] rem_fix;
  logic            last;

  assign unused_op = op_i[2];

  // Operand conditioning and special-case detection, evaluated in START
  always_comb begin
    is_signed = ~op_q[0];
    dvnd_neg  = is_signed & dvnd_q[XLEN-1];
    dvsr_neg  = is_signed & dvsr_q[XLEN-1];
    dvnd_abs  = dvnd_neg ? (~dvnd_q + XLEN'(1)) : dvnd_q;
    dvsr_abs  = dvsr_neg ? (~dvsr_q + XLEN'(1)) : dvsr_q;
    div_zero  = (dvsr_q == '0);
    overflow  = is_signed && (dvnd_q == {1'b1, {(XLEN-1){1'b0}}}) && (dvsr_q == '1);
    special   = div_zero | overflow;
    sp_quot   = div_zero ? '1 : {1'b1, {(XLEN-1){1'b0}}};
    sp_rem    = div_zero ? dvnd_q : '0;
  end

  // One restoring step; the shifted remainder needs XLEN+1 bits to compare against any divisor
  always_comb begin
    shifted  = {rem_q, quot_q[XLEN-1]};
    trial    = shifted - {1'b0, dvsr_q};
    if (!trial[XLEN]) begin
      rem_nxt  = trial[XLEN-1:0];
      quot_nxt = {quot_q[XLEN-2:0], 1'b1};
    end else begin
      rem_nxt  = shifted[XLEN-1:0];
      quot_nxt = {quot_q[XLEN-2:0], 1'b0};
    end
    quot_fix = neg_q_q ? (~quot_nxt + XLEN'(1)) : quot_nxt;
    rem_fix  = neg_r_q ? (~rem_nxt + XLEN'(1)) : rem_nxt;
    last     = (cnt_q == CNT_W'(XLEN - 1));
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_i) state_d = S_START;
      S_START: state_d = special ? S_END : S_CALC;
      S_CALC:  if (last) state_d = S_END;
      S_END:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Datapath and registered outputs; result/rd are loaded on entry to END and then held
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= '0;
      dvnd_q    <= '0;
      dvsr_q    <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      result_o  <= '0;
      ready_o   <= 1'b0;
      rd_addr_o <= '0;
      busy_o    <= 1'b0;
    end else begin
      ready_o <= 1'b0;
      busy_o  <= (state_d != S_IDLE);
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            op_q   <= op_i[1:0];
            dvnd_q <= dividend_i;
            dvsr_q <= divisor_i;
            rd_q   <= rd_addr_i;
          end
        end
        S_START: begin
          if (special) begin
            result_o  <= op_q[1] ? sp_rem : sp_quot;
            rd_addr_o <= rd_q;
            ready_o   <= 1'b1;
          end else begin
            dvsr_q  <= dvsr_abs;
            quot_q  <= dvnd_abs;
            rem_q   <= '0;
            cnt_q   <= '0;
            neg_q_q <= dvnd_neg ^ dvsr_neg;
            neg_r_q <= dvnd_neg;
          end
        end
        S_CALC: begin
          rem_q  <= rem_nxt;
          quot_q <= quot_nxt;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (last) begin
            result_o  <= op_q[1] ? rem_fix : quot_fix;
            rd_addr_o <= rd_q;
            ready_o   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign hold_req_o = ((state_q == S_IDLE) && start_i) ||
                      (state_q == S_START) || (state_q == S_CALC);

endmodule

// File: tb/tb_ex_div.sv
// Scoreboard bench for ex_div: driver pushes expected results, monitor checks each ready_o pulse.
module tb_ex_div;

  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_REM  = 3'b110;
  localparam logic [2:0] OP_REMU = 3'b111;
  localparam int LAT_N = 34;
  localparam int LAT_S = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [4:0]  rd_addr_i;
  logic [31:0] result_o;
  logic        ready_o;
  logic [4:0]  rd_addr_o;
  logic        busy_o;
  logic        hold_req_o;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          due;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  ex_div #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .op_i       (op_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .rd_addr_i  (rd_addr_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .rd_addr_o  (rd_addr_o),
    .busy_o     (busy_o),
    .hold_req_o (hold_req_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ready_o pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && ready_o) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got result 0x%08h rd %0d with nothing outstanding (cycle %0d)",
                 result_o, rd_addr_o, cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result", result_o, e.res);
        check("rd_addr", 32'(rd_addr_o), 32'(e.rd));
        check("ready_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  // Drive one start pulse; returns one cycle after the start cycle
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input int lat);
    exp_t e;
    @(posedge clk); #1;
    start_i    = 1'b1;
    op_i       = op;
    dividend_i = a;
    divisor_i  = b;
    rd_addr_i  = rd;
    e.res = exp;
    e.rd  = rd;
    e.due = cyc + lat;
    sb_q.push_back(e);
    #1;
    check("hold_on_start", 32'(hold_req_o), 32'd1);
    @(posedge clk); #1;
    start_i    = 1'b0;
    dividend_i = 32'hDEAD_BEEF;
    divisor_i  = 32'h0BAD_F00D;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d results outstanding after %0d cycles", sb_q.size(), budget);
      sb_q.delete();
    end
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input logic [31:0] exp, input int lat);
    issue(op, a, b, rd, exp, lat);
    wait_done(60);
  endtask

  initial begin
    int bad;
    rst        = 1'b1;
    start_i    = 1'b0;
    op_i       = '0;
    dividend_i = '0;
    divisor_i  = '0;
    rd_addr_i  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_result", result_o, 32'd0);
    check("reset_ready", 32'(ready_o), 32'd0);
    check("reset_rd", 32'(rd_addr_o), 32'd0);
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_hold", 32'(hold_req_o), 32'd0);

    // DIVU 100/7 with hold_req_o watched cycle by cycle
    issue(OP_DIVU, 32'd100, 32'd7, 5'd1, 32'd14, LAT_N);
    bad = 0;
    repeat (33) begin
      @(negedge clk);
      if (hold_req_o !== 1'b1) bad++;
    end
    check("hold_during_op", 32'(bad), 32'd0);
    @(negedge clk);
    check("hold_at_ready", 32'(hold_req_o), 32'd0);
    check("ready_at_end", 32'(ready_o), 32'd1);
    wait_done(5);
    repeat (4) @(negedge clk);
    check("result_held", result_o, 32'd14);
    check("rd_held", 32'(rd_addr_o), 32'd1);
    check("idle_busy", 32'(busy_o), 32'd0);

    run(OP_REMU, 32'd100, 32'd7, 5'd2, 32'd2, LAT_N);

    // Signed quotient/remainder sign rules
    run(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFD, LAT_N);
    run(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFF, LAT_N);
    run(OP_DIV, 32'd7, 32'hFFFF_FFFE, 5'd5, 32'hFFFF_FFFD, LAT_N);
    run(OP_REM, 32'd7, 32'hFFFF_FFFE, 5'd6, 32'd1, LAT_N);

    // Divide by zero and signed overflow short-cuts
    run(OP_DIVU, 32'd5, 32'd0, 5'd7, 32'hFFFF_FFFF, LAT_S);
    run(OP_REM, 32'd5, 32'd0, 5'd8, 32'd5, LAT_S);
    run(OP_DIV, 32'hFFFF_FFFB, 32'd0, 5'd9, 32'hFFFF_FFFF, LAT_S);
    run(OP_REM, 32'hFFFF_FFFB, 32'd0, 5'd10, 32'hFFFF_FFFB, LAT_S);
    run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, LAT_S);
    run(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0, LAT_S);

    // Edge magnitudes
    run(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd13, 32'hFFFF_FFFF, LAT_N);
    run(OP_DIV, 32'h8000_0000, 32'd2, 5'd14, 32'hC000_0000, LAT_N);
    run(OP_DIVU, 32'd0, 32'd13, 5'd15, 32'd0, LAT_N);
    run(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0, LAT_N);
    run(OP_REMU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'd17, 32'd1, LAT_N);

    // Start pulse while busy must be ignored
    issue(OP_DIVU, 32'd100, 32'd7, 5'd18, 32'd14, LAT_N);
    repeat (8) @(posedge clk);
    #1;
    start_i    = 1'b1;
    op_i       = OP_REMU;
    dividend_i = 32'd50;
    divisor_i  = 32'd3;
    rd_addr_i  = 5'd19;
    @(posedge clk); #1;
    start_i = 1'b0;
    wait_done(60);
    repeat (40) @(negedge clk);
    check("busy_after_ignored", 32'(busy_o), 32'd0);

    // Reset mid-operation discards the division
    issue(OP_DIVU, 32'd100, 32'd7, 5'd20, 32'd14, LAT_N);
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_hold", 32'(hold_req_o), 32'd0);
    check("rst_result", result_o, 32'd0);
    check("rst_ready", 32'(ready_o), 32'd0);
    repeat (40) @(negedge clk);
    run(OP_DIVU, 32'd9, 32'd3, 5'd21, 32'd3, LAT_N);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
